// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Multiply-occupancy FSM states.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // Hazard source that owns the pipeline this cycle, highest priority first.
  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_MEM    = 3'd1,
    SRC_MUL    = 3'd2,
    SRC_LDUSE  = 3'd3,
    SRC_BRANCH = 3'd4
  } stall_src_e;

  // Per-stage control bundle driven to the pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_bubble;
    logic memwb_bubble;
  } ctrl_t;

  // While reset is asserted every register is frozen and fed NOPs.
  localparam ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
    idex_write: 1'b0, idex_bubble: 1'b1,
    exmem_write: 1'b0, exmem_bubble: 1'b1, memwb_bubble: 1'b1
  };

  // $clog2 that never returns a zero width.
  function automatic int unsigned clog2_min1(input int unsigned val);
    int unsigned w;
    w = $clog2(val);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

  // Control pattern produced by the winning hazard source.
  function automatic ctrl_t ctrl_for(input stall_src_e src);
    ctrl_t c;
    c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
          idex_write: 1'b1, idex_bubble: 1'b0,
          exmem_write: 1'b1, exmem_bubble: 1'b0, memwb_bubble: 1'b0};
    case (src)
      SRC_MEM: begin
        // Freeze everything up to EX/MEM; MEM/WB receives a NOP.
        c.pc_write     = 1'b0;
        c.ifid_write   = 1'b0;
        c.idex_write   = 1'b0;
        c.exmem_write  = 1'b0;
        c.memwb_bubble = 1'b1;
      end
      SRC_MUL: begin
        // MUL stays in EX; a bubble travels into EX/MEM.
        c.pc_write     = 1'b0;
        c.ifid_write   = 1'b0;
        c.idex_write   = 1'b0;
        c.exmem_bubble = 1'b1;
      end
      SRC_LDUSE: begin
        // Dependent instruction waits in ID; a bubble goes into EX.
        c.pc_write    = 1'b0;
        c.ifid_write  = 1'b0;
        c.idex_bubble = 1'b1;
      end
      SRC_BRANCH: begin
        // Squash the wrong-path fetch; PC takes the branch target.
        c.ifid_flush = 1'b1;
      end
      SRC_NONE: begin
        c.pc_write = 1'b1;
      end
      default: begin
        c = CTRL_RESET;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter: counts inc_i cycles, sticks at all-ones.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_r;

  // Count up on inc_i until all-ones, then hold.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r <= '0;
    end else if (inc_i && (cnt_r != '1)) begin
      cnt_r <= cnt_r + W'(1);
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges D-memory wait, multi-cycle MUL,
// load-use and branch-taken into per-stage write/bubble/flush controls,
// with saturating perf counters and a memory-timeout watchdog.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT     = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_use_i,
  input  logic             br_flush_i,
  input  logic             ex_mul_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             exmem_bubble_o,
  output logic             memwb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o
);

  localparam int unsigned MUL_CNT_W  = clog2_min1(MUL_LAT);
  localparam int unsigned WD_W       = clog2_min1(MEM_TIMEOUT + 1);
  localparam bit          MUL_STALLS = (MUL_LAT > 1);

  mul_state_e           state_r, state_nxt_s;
  logic [MUL_CNT_W-1:0] mul_cnt_r, mul_cnt_nxt_s;
  logic [WD_W-1:0]      wd_cnt_r, wd_cnt_nxt_s;
  logic                 mem_err_r, mem_err_set_s;
  logic                 mem_stall_s;
  logic                 mul_hold_s;
  stall_src_e           src_s;
  ctrl_t                ctrl_s;
  logic                 stall_inc_s, flush_inc_s;

  // An ack in the request cycle is a zero-wait access.
  assign mem_stall_s = mem_req_i & ~mem_ack_i;

  // MUL holds on the issue cycle and while the remaining count is non-zero.
  always_comb begin
    mul_hold_s = 1'b0;
    case (state_r)
      RUN:      mul_hold_s = ex_mul_i & MUL_STALLS;
      MUL_BUSY: mul_hold_s = (mul_cnt_r != '0);
      default:  mul_hold_s = 1'b0;
    endcase
  end

  // Fixed-priority arbitration: MEM > MUL > LDUSE > BRANCH.
  always_comb begin
    src_s = SRC_NONE;
    if (mem_stall_s) begin
      src_s = SRC_MEM;
    end else if (mul_hold_s) begin
      src_s = SRC_MUL;
    end else if (ld_use_i) begin
      src_s = SRC_LDUSE;
    end else if (br_flush_i) begin
      src_s = SRC_BRANCH;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // Stage controls; reset overrides every source.
  always_comb begin
    ctrl_s = CTRL_RESET;
    if (!rst_i) begin
      ctrl_s = CTRL_RESET;
    end else begin
      ctrl_s = ctrl_for(src_s);
    end
  end

  // MUL FSM next state; a memory stall freezes it in place.
  always_comb begin
    state_nxt_s   = state_r;
    mul_cnt_nxt_s = mul_cnt_r;
    if (mem_stall_s) begin
      state_nxt_s   = state_r;
      mul_cnt_nxt_s = mul_cnt_r;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_mul_i && MUL_STALLS) begin
            state_nxt_s   = MUL_BUSY;
            mul_cnt_nxt_s = MUL_CNT_W'(MUL_LAT - 2);
          end else begin
            state_nxt_s   = RUN;
          end
        end
        MUL_BUSY: begin
          if (mul_cnt_r != '0) begin
            mul_cnt_nxt_s = mul_cnt_r - MUL_CNT_W'(1);
          end else begin
            state_nxt_s   = RUN;
          end
        end
        default: begin
          state_nxt_s   = RUN;
          mul_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // MUL FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r   <= RUN;
      mul_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      mul_cnt_r <= mul_cnt_nxt_s;
    end
  end

  // Watchdog next value: count consecutive stalls, saturating at the limit.
  always_comb begin
    wd_cnt_nxt_s  = '0;
    mem_err_set_s = 1'b0;
    if (mem_stall_s) begin
      if (wd_cnt_r != WD_W'(MEM_TIMEOUT)) begin
        wd_cnt_nxt_s = wd_cnt_r + WD_W'(1);
      end else begin
        wd_cnt_nxt_s = wd_cnt_r;
      end
      // This stall is the MEM_TIMEOUT-th in a row (or later).
      mem_err_set_s = (wd_cnt_r >= WD_W'(MEM_TIMEOUT - 1));
    end else begin
      wd_cnt_nxt_s  = '0;
      mem_err_set_s = 1'b0;
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wd_cnt_r  <= '0;
      mem_err_r <= 1'b0;
    end else begin
      wd_cnt_r  <= wd_cnt_nxt_s;
      mem_err_r <= mem_err_r | mem_err_set_s;
    end
  end

  assign stall_inc_s = rst_i & ~ctrl_s.pc_write;
  assign flush_inc_s = rst_i & ctrl_s.ifid_flush;

  perf_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc_s),
    .cnt_o (stall_cnt_o)
  );

  perf_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc_s),
    .cnt_o (flush_cnt_o)
  );

  assign pc_write_o     = ctrl_s.pc_write;
  assign ifid_write_o   = ctrl_s.ifid_write;
  assign ifid_flush_o   = ctrl_s.ifid_flush;
  assign idex_write_o   = ctrl_s.idex_write;
  assign idex_bubble_o  = ctrl_s.idex_bubble;
  assign exmem_write_o  = ctrl_s.exmem_write;
  assign exmem_bubble_o = ctrl_s.exmem_bubble;
  assign memwb_bubble_o = ctrl_s.memwb_bubble;
  assign mem_err_o      = mem_err_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios then
// random traffic, compared every cycle against a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int MUL_LAT     = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i, ld_use_i, br_flush_i, ex_mul_i, mem_req_i, mem_ack_i;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o;
  logic             idex_bubble_o, exmem_write_o, exmem_bubble_o, memwb_bubble_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic             mem_err_o;

  int checks = 0;
  int errors = 0;

  // Model state: cycles left in the current MUL (incl. release), counts.
  int busy_left = 0;
  int m_stall   = 0;
  int m_flush   = 0;
  int m_consec  = 0;
  bit m_err     = 1'b0;

  pipeline_stall_ctrl #(
    .MUL_LAT(MUL_LAT), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ld_use_i(ld_use_i), .br_flush_i(br_flush_i),
    .ex_mul_i(ex_mul_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_write_o(idex_write_o), .idex_bubble_o(idex_bubble_o),
    .exmem_write_o(exmem_write_o), .exmem_bubble_o(exmem_bubble_o),
    .memwb_bubble_o(memwb_bubble_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after negedge, check mid-cycle, advance model at posedge.
  task automatic step(input bit rst, input bit ld, input bit br, input bit mul,
                      input bit req, input bit ack);
    logic [7:0] exp;
    logic [7:0] obs;
    bit ms, mh;
    rst_i = rst; ld_use_i = ld; br_flush_i = br; ex_mul_i = mul;
    mem_req_i = req; mem_ack_i = ack;
    #1;
    ms = req && !ack;
    mh = (busy_left > 1) || (busy_left == 0 && mul && MUL_LAT > 1);
    // bits: pc_w ifid_w ifid_f idex_w idex_b exmem_w exmem_b memwb_b
    if (!rst)     exp = 8'b0000_1011;
    else if (ms)  exp = 8'b0000_0001;
    else if (mh)  exp = 8'b0000_0110;
    else if (ld)  exp = 8'b0001_1100;
    else if (br)  exp = 8'b1111_0100;
    else          exp = 8'b1101_0100;
    obs = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
           exmem_write_o, exmem_bubble_o, memwb_bubble_o};
    chk("ctrl", 64'(obs), 64'(exp));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt_o), 64'(m_flush));
    chk("mem_err", 64'(mem_err_o), 64'(m_err));
    @(posedge clk_i);
    if (!rst) begin
      busy_left = 0; m_stall = 0; m_flush = 0; m_consec = 0; m_err = 1'b0;
    end else begin
      if (!exp[7] && m_stall < CMAX) m_stall++;
      if (exp[5] && m_flush < CMAX) m_flush++;
      if (ms) begin
        if (m_consec < MEM_TIMEOUT) m_consec++;
        if (m_consec >= MEM_TIMEOUT) m_err = 1'b1;
      end else begin
        m_consec = 0;
        if (busy_left > 0) busy_left--;
        else if (mul && MUL_LAT > 1) busy_left = MUL_LAT - 1;
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    bit req_hold;
    bit rq, ak, rs;
    req_hold = 1'b0;
    rst_i = 1'b0; ld_use_i = 1'b0; br_flush_i = 1'b0; ex_mul_i = 1'b0;
    mem_req_i = 1'b0; mem_ack_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);

    // Reset held 3 cycles, then idle.
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single load-use cycle.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use with branch, then branch alone.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // MUL: 3 holds, release on the 4th cycle.
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // MUL with a memory stall on hold cycle 2, ack in the following cycle.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Memory wait of 5 cycles, then ack with a load-use in the ack cycle.
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    // Zero-wait access.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Watchdog: 10 stall cycles, ack, idle, then reset clears the flag.
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a MUL.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic; requests are held until acked.
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 149) != 0);
      rq = req_hold || ($urandom_range(0, 3) == 0);
      ak = rq && ($urandom_range(0, 2) == 0);
      req_hold = rs && rq && !ak;
      step(rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), rq, ak);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
